// File: rtl/conv_ctrl_pkg.sv
// Shared types and constants for the convolution stream sequencer.
package conv_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_SOF = 2'd1,
    RUN      = 2'd2,
    DONE     = 2'd3
  } state_t;

  localparam int unsigned ERR_TLAST = 0;
  localparam int unsigned ERR_CFG   = 1;

endpackage

// File: rtl/conv_pos_counter.sv
// Column/row pixel position counter with clear, hold, line wrap and an
// optional start-of-frame override that treats the current beat as (0,0).
module conv_pos_counter #(
  parameter int unsigned COL_W = 14,
  parameter int unsigned ROW_W = 14
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             clr,
  input  logic             adv,
  input  logic             sof,
  input  logic [COL_W-1:0] width,
  input  logic [ROW_W-1:0] height,
  output logic [COL_W-1:0] col,
  output logic [ROW_W-1:0] row,
  output logic             col_last,
  output logic             last
);

  logic [COL_W-1:0] col_q;
  logic [ROW_W-1:0] row_q;

  // The position presented to the datapath is (0,0) when sof overrides the count.
  always_comb begin
    col      = sof ? '0 : col_q;
    row      = sof ? '0 : row_q;
    col_last = (col == width - COL_W'(1));
    last     = col_last && (row == height - ROW_W'(1));
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      col_q <= '0;
      row_q <= '0;
    end else if (clr) begin
      col_q <= '0;
      row_q <= '0;
    end else if (adv) begin
      if (col_last) begin
        col_q <= '0;
        row_q <= row + ROW_W'(1);
      end else begin
        col_q <= col + COL_W'(1);
        row_q <= row;
      end
    end
  end

endmodule

// File: rtl/conv_stream_sequencer.sv
// Frame/line sequencer for the line-buffer convolution datapath.
// Optional build macro: CONV_SOF_RESYNC_EN (tuser in RUN restarts the frame at (0,0)).
module conv_stream_sequencer
  import conv_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH    = 14,
  parameter int unsigned COL_W         = 14,
  parameter int unsigned ROW_W         = 14,
  parameter int unsigned KERNEL_WIDTH  = 3,
  parameter int unsigned KERNEL_HEIGHT = 3
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  start,
  input  logic [COL_W-1:0]      cfg_width,
  input  logic [ROW_W-1:0]      cfg_height,
  input  logic                  s_tvalid,
  input  logic                  s_tuser,
  input  logic                  s_tlast,
  output logic                  s_tready,
  input  logic                  m_tready,
  output logic                  we,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic                  eol,
  output logic                  win_valid,
  output logic                  o_tuser,
  output logic                  o_tlast,
  output logic                  busy,
  output logic                  frame_done,
  output logic [1:0]            err
);

  state_t           state, state_n;
  logic [COL_W-1:0] width_q;
  logic [ROW_W-1:0] height_q;

  logic             accept;
  logic             cfg_bad;
  logic             wr_pix;
  logic             resync;
  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;
  logic             col_last;
  logic             last;
  logic             win_pix;

  assign s_tready   = m_tready && ((state == WAIT_SOF) || (state == RUN));
  assign accept     = s_tvalid && s_tready;
  assign busy       = (state != IDLE);
  assign frame_done = (state == DONE);
  assign cfg_bad    = (cfg_width < COL_W'(KERNEL_WIDTH)) || (cfg_height < ROW_W'(KERNEL_HEIGHT));

`ifdef CONV_SOF_RESYNC_EN
  assign resync = (state == RUN) && accept && s_tuser;
`else
  assign resync = 1'b0;
`endif

  // Beats discarded while hunting for SOF never reach the line buffer.
  assign wr_pix  = accept && ((state == RUN) || ((state == WAIT_SOF) && s_tuser));
  assign win_pix = (row >= ROW_W'(KERNEL_HEIGHT - 1)) && (col >= COL_W'(KERNEL_WIDTH - 1));

  conv_pos_counter #(
    .COL_W (COL_W),
    .ROW_W (ROW_W)
  ) u_pos (
    .clk      (clk),
    .resetn   (resetn),
    .clr      (state == IDLE),
    .adv      (wr_pix),
    .sof      (resync),
    .width    (width_q),
    .height   (height_q),
    .col      (col),
    .row      (row),
    .col_last (col_last),
    .last     (last)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:     if (start && !cfg_bad)             state_n = WAIT_SOF;
      WAIT_SOF: if (accept && s_tuser)             state_n = RUN;
      RUN:      if (wr_pix && last && !resync)     state_n = DONE;
      DONE:                                        state_n = IDLE;
      default:                                     state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      width_q  <= '0;
      height_q <= '0;
    end else if ((state == IDLE) && start) begin
      width_q  <= cfg_width;
      height_q <= cfg_height;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      we        <= 1'b0;
      wr_addr   <= '0;
      eol       <= 1'b0;
      win_valid <= 1'b0;
      o_tuser   <= 1'b0;
      o_tlast   <= 1'b0;
    end else begin
      we        <= wr_pix;
      wr_addr   <= wr_pix ? ADDR_WIDTH'(col) : '0;
      eol       <= wr_pix && col_last;
      win_valid <= wr_pix && win_pix;
      o_tuser   <= wr_pix && (row == ROW_W'(KERNEL_HEIGHT - 1)) && (col == COL_W'(KERNEL_WIDTH - 1));
      o_tlast   <= wr_pix && win_pix && col_last;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      err <= '0;
    end else if ((state == IDLE) && start) begin
      err            <= '0;
      err[ERR_CFG]   <= cfg_bad;
    end else if (wr_pix && (s_tlast != col_last)) begin
      err[ERR_TLAST] <= 1'b1;
    end
  end

endmodule
